icache_responder: RTL
=====================

Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that answers the fetch stage's per-cycle group of SUPER PC requests.
- Returns one instruction word and a valid bit per lane, registered one cycle after the request.
- Sits between fetch and the memory/L2 port. Misses are refilled a full line at a time by an internal state machine.
- Fetch treats any invalid lane as not-yet-available and re-presents the same PCs (stall) until they hit.

Parameters:
SUPER, 4, fetch lanes per cycle (matches fetch width)
SETS, 64, number of cache lines; power of two
LINE_WORDS, 8, 32-bit words per line; power of two, >= SUPER

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
req_pc  input  SUPER x 32  lane i PC; fetch guarantees req_pc[i] = req_pc[0] + 4*i
flush  input  1  invalidate entire cache
rd_data  output  SUPER x 32  instruction word per lane, for request of previous cycle
rd_valid  output  SUPER  lane hit for request of previous cycle
busy  output  1  high when state != IDLE
mem_req_valid  output  1  line refill request
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  line-aligned refill byte address
mem_resp_valid  input  1  one refill beat present
mem_resp_data  input  32  refill word, ascending word order

Behaviour:
- Address split:
  - bits [1:0]: ignored.
  - OFF: next log2(LINE_WORDS) bits.
  - IDX: next log2(SETS) bits.
  - TAG: remainder.
- Storage: data[SETS][LINE_WORDS], tag[SETS], vbit[SETS].
- Reset: all vbit=0, state=IDLE, rd_valid=0, rd_data=0, mem_req_valid=0, mem_req_addr=0, beat counter=0, flush_seen=0, busy=0. Reset mid-refill abandons the refill; later mem_resp beats are ignored.
- Latency: req_pc is sampled at edge N. rd_data/rd_valid are registered and update at edge N+1.
- Hit rule, evaluated in IDLE only: lane i is valid iff
  - vbit[IDX0]=1, and
  - tag[IDX0]=TAG0, and
  - req_pc[i] has the same TAG/IDX as req_pc[0] (no line crossing).
- Lanes past the line end return valid=0. Their rd_data is don't-care; drive the word of the same line at OFF wrap.
- Lanes are independent of each other otherwise; a valid lane is never preceded by an invalid lane.
- FSM IDLE:
  - On lane-0 miss (and flush=0): latch miss line address {TAG0,IDX0,0...}, go to REQ. All rd_valid=0 for this request.
  - On hit: stay in IDLE.
- FSM REQ:
  - mem_req_valid=1; mem_req_addr held stable until the handshake.
  - When mem_req_valid & mem_req_ready: counter=0, go to FILL.
- FSM FILL:
  - Each mem_resp_valid writes data[idx][counter] and increments counter.
  - On the beat with counter=LINE_WORDS-1:
    - write tag;
    - set vbit only if flush_seen=0;
    - clear flush_seen;
    - go to IDLE.
- mem_resp_valid outside FILL is ignored.
- During REQ/FILL: all rd_valid=0, lookups are not performed, and new PCs (redirects) are not tracked. The refill always completes.
- Cycle after return to IDLE: lookup sees the updated arrays, so the re-presented PC hits.
- Flush:
  - Clears all vbit at the next edge, in any state.
  - If asserted in REQ/FILL, sets flush_seen so the in-flight line is not validated.
  - In IDLE, the flush cycle's lookup returns all-invalid and does not start a refill.
- Flush concurrent with the final FILL beat: the line is not validated.
- Width: counter is log2(LINE_WORDS) bits and wraps naturally; PC arithmetic is modulo 2^32.

Test Plan:
- Cold miss: reset, req_pc[0]=0x100 held (SUPER=4, LINE_WORDS=8) -> rd_valid=0000. Then mem_req_valid with addr 0x100. Feed 8 beats 0xA0..0xA7 -> busy drops. The next request cycle returns rd_valid=1111, rd_data=A0,A1,A2,A3.
- Line crossing: after filling 0x100, request 0x118 -> rd_valid=0011, data A6,A7. Then request 0x120 -> miss, refill addr 0x120.
- Backpressure: hold mem_req_ready=0 for 5 cycles -> mem_req_valid=1 and addr stable throughout; gaps between mem_resp beats -> counter advances only on valid beats.
- Flush: fill 0x100, pulse flush -> the next request for 0x100 misses and refills. Flush during FILL beat 3 -> after completion, 0x100 still misses.
- Conflict: fill 0x100, then request 0x100+SETS*LINE_WORDS*4 -> miss, refill replaces the set, and 0x100 then misses.
- Reset during FILL beat 4 -> busy=0, rd_valid=0, mem_req_valid=0. The remaining stray beats leave no valid line.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The cache uses the slave modport; fetch/memory models use master.
interface icache_responder_if #(
  parameter int SUPER = 4
);
  logic [SUPER-1:0][31:0] req_pc;
  logic                   flush;
  logic [SUPER-1:0][31:0] rd_data;
  logic [SUPER-1:0]       rd_valid;
  logic                   busy;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [31:0]            mem_req_addr;
  logic                   mem_resp_valid;
  logic [31:0]            mem_resp_data;

  modport slave (
    input  req_pc, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output rd_data, rd_valid, busy, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_pc, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  rd_data, rd_valid, busy, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering SUPER fetch lanes per
// cycle, with a whole-line refill state machine behind it.
//
// state | meaning
// IDLE  | lookups active; a lane-0 miss latches the line address
// REQ   | refill request presented until memory accepts it
// FILL  | collecting LINE_WORDS beats into the victim set
module icache_responder #(
  parameter int SUPER      = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  icache_responder_if.slave bus
);
  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_W    = $clog2(SETS);
  localparam int LINE_LSB = 2 + OFF_W;
  localparam int TAG_LSB  = LINE_LSB + IDX_W;
  localparam int TAG_W    = 32 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]       tag_q  [SETS];
  logic [SETS-1:0]        vbit_q;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            miss_addr_q, miss_addr_d;
  logic                   flush_seen_q, flush_seen_d;
  logic [SUPER-1:0][31:0] rd_data_q, rd_data_d;
  logic [SUPER-1:0]       rd_valid_q, rd_valid_d;

  logic [IDX_W-1:0]       idx0;
  logic [TAG_W-1:0]       tag0;
  logic                   hit0;
  logic [OFF_W-1:0]       lane_off [SUPER];
  logic [SUPER-1:0]       same_line;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   fill_we;
  logic                   fill_last;
  logic                   unused_pc_bits;

  assign idx0     = bus.req_pc[0][TAG_LSB-1:LINE_LSB];
  assign tag0     = bus.req_pc[0][31:TAG_LSB];
  assign hit0     = vbit_q[idx0] && (tag_q[idx0] == tag0);
  assign fill_idx = miss_addr_q[TAG_LSB-1:LINE_LSB];
  assign fill_tag = miss_addr_q[31:TAG_LSB];

  // Per-lane word select inside lane 0's line; lanes past the line end wrap.
  always_comb begin
    unused_pc_bits = 1'b0;
    for (int i = 0; i < SUPER; i++) begin
      lane_off[i]     = bus.req_pc[i][LINE_LSB-1:2];
      same_line[i]    = (bus.req_pc[i][31:LINE_LSB] == bus.req_pc[0][31:LINE_LSB]);
      rd_data_d[i]    = data_q[idx0][lane_off[i]];
      unused_pc_bits  = unused_pc_bits ^ (^bus.req_pc[i][1:0]);
    end
  end

  // Next-state logic: lookup in IDLE, request handshake, beat collection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_addr_d  = miss_addr_q;
    flush_seen_d = flush_seen_q;
    rd_valid_d   = '0;
    fill_we      = 1'b0;
    fill_last    = 1'b0;
    if (bus.flush && (state_q != IDLE)) flush_seen_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (!bus.flush) begin
          if (hit0) begin
            rd_valid_d = same_line;
          end else begin
            miss_addr_d = {bus.req_pc[0][31:LINE_LSB], {LINE_LSB{1'b0}}};
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_resp_valid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            fill_last    = 1'b1;
            flush_seen_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_addr_q  <= '0;
      flush_seen_q <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_addr_q  <= miss_addr_d;
      flush_seen_q <= flush_seen_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Valid bits: flush wins over a completing refill; a flushed refill never validates.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vbit_q <= '0;
    end else if (fill_last && !flush_seen_q) begin
      vbit_q[fill_idx] <= 1'b1;
    end
  end

  // Data and tag arrays are written only by the refill and need no reset.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      data_q[fill_idx][cnt_q] <= bus.mem_resp_data;
      if (fill_last) tag_q[fill_idx] <= fill_tag;
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = miss_addr_q;
endmodule
